piso_shift_register: RTL and testbench



---
 rtl/piso_shift_register.sv | 74 +++++++
 tb/tb_piso_shift_register.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register.
// Captures a WIDTH-bit word on a load strobe and emits it one bit per clock,
// MSB first (MSB_FIRST=1) or LSB first (MSB_FIRST=0). The valid, last and
// bit_count outputs let downstream logic frame each serialized word.
//
// Handshake: there is no backpressure. valid is a status strobe, not a request.
// While valid=1, serial_out carries a bit of the most recently loaded word,
// and the sink must take that bit in the same cycle. last marks the final
// bit of the word. A load restarts serialization on the next edge and
// discards any bits of the previous word that have not been sent yet.
module piso_shift_register #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [WIDTH-1:0]           parallel_in,
    output logic                       serial_out,
    output logic                       valid,
    output logic                       last,
    output logic [$clog2(WIDTH+1)-1:0] bit_count
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr_shifted;

    // Move the register one place toward the output end and fill the vacated bit with zero.
    always_comb begin
        sr_shifted = '0;
        if (MSB_FIRST)
            sr_shifted = {sr[WIDTH-2:0], 1'b0};
        else
            sr_shifted = {1'b0, sr[WIDTH-1:1]};
    end

    // A load takes priority. Otherwise the register shifts every cycle,
    // including the cycles after the word has been fully sent.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= parallel_in;
        end else begin
            sr <= sr_shifted;
        end
    end

    // Track the bits still to be sent. valid drops on the shift that follows the final bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            cnt   <= CW'(WIDTH - 1);
            valid <= 1'b1;
        end else if (cnt != '0) begin
            cnt   <= cnt - CW'(1);
        end else begin
            valid <= 1'b0;
        end
    end

    // Outputs are decoded from registers only, so no input reaches serial_out combinationally.
    always_comb begin
        serial_out = MSB_FIRST ? sr[WIDTH-1] : sr[0];
        last       = valid && (cnt == '0);
        bit_count  = valid ? (cnt + CW'(1)) : '0;
    end

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed testbench for piso_shift_register.
// The bench has two instances. u_msb uses the default WIDTH=4 and shifts MSB
// first. u_lsb uses WIDTH=8 and shifts LSB first. Both instances share the
// clock and the active-low reset.
module tb_piso_shift_register;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] parallel_in;
    logic       serial_out;
    logic       valid;
    logic       last;
    logic [2:0] bit_count;

    logic       load8;
    logic [7:0] parallel_in8;
    logic       serial_out8;
    logic       valid8;
    logic       last8;
    logic [3:0] bit_count8;

    int checks;
    int errors;

    piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .parallel_in (parallel_in),
        .serial_out  (serial_out),
        .valid       (valid),
        .last        (last),
        .bit_count   (bit_count)
    );

    piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk         (clk),
        .reset       (reset),
        .load        (load8),
        .parallel_in (parallel_in8),
        .serial_out  (serial_out8),
        .valid       (valid8),
        .last        (last8),
        .bit_count   (bit_count8)
    );

    // Clock generation: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then settle 1 ns before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs stay at reset values while reset is held, even while load toggles.
    // The first edge after release then loads normally.
    task automatic test_reset();
        logic [5:0] obs;
        logic [6:0] obs8;
        reset = 1'b0;
        parallel_in = 4'b1111;
        parallel_in8 = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            load  = i[0] ? 1'b0 : 1'b1;
            load8 = load;
            step();
            obs  = {serial_out, valid, last, bit_count};
            obs8 = {serial_out8, valid8, last8, bit_count8};
            checks++;
            if (obs !== 6'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d] u_msb got %b expected %b", i, obs, 6'b0);
            end
            checks++;
            if (obs8 !== 7'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d] u_lsb got %b expected %b", i, obs8, 7'b0);
            end
        end
        load  = 1'b1;
        load8 = 1'b0;
        parallel_in = 4'b1011;
        reset = 1'b1;
        step();
        obs = {serial_out, valid, last, bit_count};
        checks++;
        if (obs !== 6'b1_1_0_100) begin
            errors++;
            $display("FAIL release_load got %b expected %b", obs, 6'b1_1_0_100);
        end
        load = 1'b0;
        for (int i = 0; i < 4; i++) step();
        obs = {serial_out, valid, last, bit_count};
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL release_drain got %b expected %b", obs, 6'b0);
        end
    endtask

    // One word, 1011, shifted MSB first. A fifth sample confirms the idle state after the word.
    task automatic test_single_word();
        logic [5:0] exp_v [5] = '{6'b1_1_0_100, 6'b0_1_0_011, 6'b1_1_0_010,
                                  6'b1_1_1_001, 6'b0_0_0_000};
        logic [5:0] obs;
        for (int i = 0; i < 5; i++) begin
            load = (i == 0);
            parallel_in = 4'b1011;
            step();
            obs = {serial_out, valid, last, bit_count};
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL single_word[%0d] got %b expected %b", i, obs, exp_v[i]);
            end
        end
    endtask

    // Two words with no gap: 1011, then 1100 loaded right after the last bit of the first word.
    task automatic test_back_to_back();
        logic       ld_v  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] din_v [9] = '{4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b1100,
                                  4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [5:0] exp_v [9] = '{6'b1_1_0_100, 6'b0_1_0_011, 6'b1_1_0_010, 6'b1_1_1_001,
                                  6'b1_1_0_100, 6'b1_1_0_011, 6'b0_1_0_010, 6'b0_1_1_001,
                                  6'b0_0_0_000};
        logic [5:0] obs;
        for (int i = 0; i < 9; i++) begin
            load = ld_v[i];
            parallel_in = din_v[i];
            step();
            obs = {serial_out, valid, last, bit_count};
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d] got %b expected %b", i, obs, exp_v[i]);
            end
        end
    endtask

    // Load 1011, then reload 0110 after two bits. The old word never raises last.
    task automatic test_mid_reload();
        logic       ld_v  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] din_v [7] = '{4'b1011, 4'b0000, 4'b0110, 4'b0000, 4'b0000,
                                  4'b0000, 4'b0000};
        logic [5:0] exp_v [7] = '{6'b1_1_0_100, 6'b0_1_0_011, 6'b0_1_0_100, 6'b1_1_0_011,
                                  6'b1_1_0_010, 6'b0_1_1_001, 6'b0_0_0_000};
        logic [5:0] obs;
        for (int i = 0; i < 7; i++) begin
            load = ld_v[i];
            parallel_in = din_v[i];
            step();
            obs = {serial_out, valid, last, bit_count};
            checks++;
            if (obs !== exp_v[i]) begin
                errors++;
                $display("FAIL mid_reload[%0d] got %b expected %b", i, obs, exp_v[i]);
            end
        end
    endtask

    // Reset asserted between edges must clear the outputs before the next rising edge.
    task automatic test_async_reset();
        logic [5:0] obs;
        load = 1'b1;
        parallel_in = 4'b1111;
        load8 = 1'b1;
        parallel_in8 = 8'b1111_0001;
        step();
        load = 1'b0;
        load8 = 1'b0;
        step();
        obs = {serial_out, valid, last, bit_count};
        checks++;
        if (obs !== 6'b1_1_0_011) begin
            errors++;
            $display("FAIL async_pre got %b expected %b", obs, 6'b1_1_0_011);
        end
        #2;
        reset = 1'b0;
        #1;
        obs = {serial_out, valid, last, bit_count};
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL async_clear u_msb got %b expected %b", obs, 6'b0);
        end
        checks++;
        if ({serial_out8, valid8, last8, bit_count8} !== 7'b0) begin
            errors++;
            $display("FAIL async_clear u_lsb got %b expected %b",
                     {serial_out8, valid8, last8, bit_count8}, 7'b0);
        end
        step();
        reset = 1'b1;
        step();
        obs = {serial_out, valid, last, bit_count};
        checks++;
        if (obs !== 6'b0) begin
            errors++;
            $display("FAIL async_after_release got %b expected %b", obs, 6'b0);
        end
    endtask

    // LSB-first, WIDTH=8: the word 1000_0110 is sent as 0,1,1,0,0,0,0,1, and last is high on the eighth bit.
    task automatic test_lsb_first();
        logic [7:0] bits = 8'b1000_0110;
        logic [6:0] exp_o;
        logic [6:0] obs8;
        for (int i = 0; i < 9; i++) begin
            load8 = (i == 0);
            parallel_in8 = 8'b1000_0110;
            step();
            if (i < 8)
                exp_o = {bits[i], 1'b1, (i == 7), 4'(8 - i)};
            else
                exp_o = 7'b0;
            obs8 = {serial_out8, valid8, last8, bit_count8};
            checks++;
            if (obs8 !== exp_o) begin
                errors++;
                $display("FAIL lsb_first[%0d] got %b expected %b", i, obs8, exp_o);
            end
        end
    endtask

    // Run the scenarios in order, then print the summary.
    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        load = 1'b0;
        load8 = 1'b0;
        parallel_in = '0;
        parallel_in8 = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_mid_reload();
        test_async_reset();
        test_lsb_first();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
